// File: rtl/fp_mult_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fp_mult_result_fifo
// Purpose  : FWFT result FIFO behind the FP multiplier, with sticky exception
//            flags and a saturating accepted-result counter.
// Revision : 1.0 - initial release
// ============================================================================
module fp_mult_result_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     d_clk,
    input  logic                     d_rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_z,
    input  logic [7:0]               in_status,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_z,
    output logic [7:0]               out_status,
    output logic [7:0]               sticky_status,
    input  logic                     sticky_clr,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         result_cnt,
    output logic                     cnt_sat
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_LVL_W = c_PTR_W + 1;
    localparam logic [c_LVL_W-1:0] c_FULL  = c_LVL_W'(DEPTH);

    logic [31:0]        r_z_mem [DEPTH];
    logic [7:0]         r_s_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic [7:0]         r_sticky;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_push;
    logic               w_pop;

    // Flow control depends on occupancy only, so in_ready never combinationally follows out_ready
    assign in_ready  = (r_level != c_FULL);
    assign out_valid = (r_level != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    assign out_z         = out_valid ? r_z_mem[r_rd_ptr] : 32'h0;
    assign out_status    = out_valid ? r_s_mem[r_rd_ptr] : 8'h0;
    assign level         = r_level;
    assign sticky_status = r_sticky;
    assign result_cnt    = r_cnt;
    assign cnt_sat       = &r_cnt;

    // Storage is intentionally not reset; reads are masked while empty
    always_ff @(posedge d_clk) begin
        if (w_push) begin
            r_z_mem[r_wr_ptr] <= in_z;
            r_s_mem[r_wr_ptr] <= in_status;
        end
    end

    always_ff @(posedge d_clk or negedge d_rst) begin
        if (!d_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + c_LVL_W'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - c_LVL_W'(1);
            end
        end
    end

    always_ff @(posedge d_clk or negedge d_rst) begin
        if (!d_rst) begin
            r_sticky <= '0;
            r_cnt    <= '0;
        end else begin
            r_sticky <= (sticky_clr ? 8'h0 : r_sticky) | (w_push ? in_status : 8'h0);
            if (w_push && !(&r_cnt)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire
